// File: rtl/snake_body_engine.sv
// Snake body engine: segment store, move/grow/collision on Step, registered row-bitmap scan port.
// Latency: state/segments visible 1 cycle after Step/Start, row query 1 cycle; no backpressure.
module snake_body_engine #(
    parameter int COORD_W  = 4,
    parameter int MAX_LEN  = 32,
    parameter int INIT_LEN = 3,
    parameter int WRAP     = 0,
    parameter int LEN_W    = $clog2(MAX_LEN + 1)
) (
    input  logic                            i_clk,
    input  logic                            i_rst_n,
    input  logic                            i_start,
    input  logic                            i_step,
    input  logic                            i_dir_valid,
    input  logic [1:0]                      i_dir_req,
    input  logic                            i_grow,
    input  logic                            i_scan_valid,
    input  logic [COORD_W-1:0]              i_scan_row,
    output logic [1:0]                      o_state,
    output logic [2*COORD_W-1:0]            o_head,
    output logic [LEN_W-1:0]                o_length,
    output logic                            o_full,
    output logic                            o_hit_wall,
    output logic                            o_hit_body,
    output logic [MAX_LEN*2*COORD_W-1:0]    o_body_flat,
    output logic                            o_row_valid,
    output logic [2**COORD_W-1:0]           o_row_bits
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DEAD = 2'b10
    } state_t;

    localparam logic [1:0] D_UP    = 2'b00;
    localparam logic [1:0] D_DOWN  = 2'b01;
    localparam logic [1:0] D_LEFT  = 2'b10;
    localparam logic [1:0] D_RIGHT = 2'b11;

    localparam logic [COORD_W-1:0] C_MID = COORD_W'(2**(COORD_W-1));
    localparam logic [COORD_W-1:0] C_MAX = {COORD_W{1'b1}};
    localparam logic [LEN_W-1:0]   L_INIT = LEN_W'(INIT_LEN);
    localparam logic [LEN_W-1:0]   L_MAX  = LEN_W'(MAX_LEN);

    state_t                 r_state;
    logic [COORD_W-1:0]     r_seg_x [MAX_LEN];
    logic [COORD_W-1:0]     r_seg_y [MAX_LEN];
    logic [LEN_W-1:0]       r_len;
    logic                   r_full;
    logic [1:0]             r_dir;
    logic [1:0]             r_pend;
    logic                   r_grow_pend;
    logic                   r_hit_wall;
    logic                   r_hit_body;
    logic                   r_row_vld;
    logic [2**COORD_W-1:0]  r_row_bits;

    logic [COORD_W-1:0]     w_nx;
    logic [COORD_W-1:0]     w_ny;
    logic                   w_edge;
    logic                   w_wall_hit;
    logic                   w_body_hit;
    logic                   w_grow_now;
    logic [LEN_W-1:0]       w_chk_len;
    logic [LEN_W-1:0]       w_new_len;
    logic                   w_run;
    logic                   w_start_ok;
    logic                   w_step;
    logic                   w_move;
    logic [1:0]             w_dir_ref;
    logic                   w_dir_ok;
    logic [2**COORD_W-1:0]  w_row_bits;

    always_comb begin
        w_nx   = r_seg_x[0];
        w_ny   = r_seg_y[0];
        w_edge = 1'b0;
        case (r_pend)
            D_UP:    begin w_ny = r_seg_y[0] - COORD_W'(1); w_edge = (r_seg_y[0] == '0);    end
            D_DOWN:  begin w_ny = r_seg_y[0] + COORD_W'(1); w_edge = (r_seg_y[0] == C_MAX); end
            D_LEFT:  begin w_nx = r_seg_x[0] - COORD_W'(1); w_edge = (r_seg_x[0] == '0);    end
            default: begin w_nx = r_seg_x[0] + COORD_W'(1); w_edge = (r_seg_x[0] == C_MAX); end
        endcase
    end

    // The natural modulo arithmetic above is the wrap; a wall only exists when not wrapping.
    assign w_wall_hit = (WRAP == 0) && w_edge;
    assign w_grow_now = (r_grow_pend || i_grow) && (r_len < L_MAX);
    assign w_chk_len  = w_grow_now ? r_len : r_len - LEN_W'(1);
    assign w_new_len  = w_grow_now ? r_len + LEN_W'(1) : r_len;

    always_comb begin
        w_body_hit = 1'b0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if (LEN_W'(i) < w_chk_len && r_seg_x[i] == w_nx && r_seg_y[i] == w_ny)
                w_body_hit = 1'b1;
        end
    end

    assign w_run      = (r_state == ST_RUN);
    assign w_start_ok = i_start && !w_run;
    assign w_step     = w_run && i_step;
    assign w_move     = w_step && !w_wall_hit && !w_body_hit;
    // Reversal is judged against the direction that will be committed after this edge.
    assign w_dir_ref  = w_move ? r_pend : r_dir;
    assign w_dir_ok   = w_run && i_dir_valid && (i_dir_req != (w_dir_ref ^ 2'b01));

    always_comb begin
        w_row_bits = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if (LEN_W'(i) < r_len && r_seg_y[i] == i_scan_row)
                w_row_bits[r_seg_x[i]] = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= ST_IDLE;
            r_len       <= L_INIT;
            r_full      <= (INIT_LEN == MAX_LEN);
            r_dir       <= D_RIGHT;
            r_pend      <= D_RIGHT;
            r_grow_pend <= 1'b0;
            r_hit_wall  <= 1'b0;
            r_hit_body  <= 1'b0;
            r_row_vld   <= 1'b0;
            r_row_bits  <= '0;
            for (int i = 0; i < MAX_LEN; i++) begin
                r_seg_x[i] <= (i < INIT_LEN) ? C_MID - COORD_W'(i) : '0;
                r_seg_y[i] <= (i < INIT_LEN) ? C_MID : '0;
            end
        end else begin
            r_hit_wall <= 1'b0;
            r_hit_body <= 1'b0;
            r_row_vld  <= i_scan_valid;
            if (i_scan_valid)
                r_row_bits <= w_row_bits;

            if (w_start_ok) begin
                r_state     <= ST_RUN;
                r_len       <= L_INIT;
                r_full      <= (INIT_LEN == MAX_LEN);
                r_dir       <= D_RIGHT;
                r_pend      <= D_RIGHT;
                r_grow_pend <= 1'b0;
                for (int i = 0; i < MAX_LEN; i++) begin
                    r_seg_x[i] <= (i < INIT_LEN) ? C_MID - COORD_W'(i) : '0;
                    r_seg_y[i] <= (i < INIT_LEN) ? C_MID : '0;
                end
            end else if (w_run) begin
                if (w_dir_ok)
                    r_pend <= i_dir_req;
                if (w_step) begin
                    if (w_wall_hit) begin
                        r_state    <= ST_DEAD;
                        r_hit_wall <= 1'b1;
                    end else if (w_body_hit) begin
                        r_state    <= ST_DEAD;
                        r_hit_body <= 1'b1;
                    end else begin
                        // Slots beyond the new length are zeroed so Body_flat needs no masking.
                        r_seg_x[0] <= w_nx;
                        r_seg_y[0] <= w_ny;
                        for (int i = 1; i < MAX_LEN; i++) begin
                            r_seg_x[i] <= (LEN_W'(i) < w_new_len) ? r_seg_x[i-1] : '0;
                            r_seg_y[i] <= (LEN_W'(i) < w_new_len) ? r_seg_y[i-1] : '0;
                        end
                        r_dir       <= r_pend;
                        r_len       <= w_new_len;
                        r_full      <= (w_new_len == L_MAX);
                        r_grow_pend <= 1'b0;
                    end
                end else if (i_grow) begin
                    r_grow_pend <= 1'b1;
                end
            end
        end
    end

    genvar g;
    generate
        for (g = 0; g < MAX_LEN; g++) begin : g_flat
            assign o_body_flat[g*2*COORD_W +: 2*COORD_W] = {r_seg_x[g], r_seg_y[g]};
        end
    endgenerate

    assign o_state     = r_state;
    assign o_head      = {r_seg_x[0], r_seg_y[0]};
    assign o_length    = r_len;
    assign o_full      = r_full;
    assign o_hit_wall  = r_hit_wall;
    assign o_hit_body  = r_hit_body;
    assign o_row_valid = r_row_vld;
    assign o_row_bits  = r_row_bits;

endmodule

// File: doc/snake_body_engine.md
# snake_body_engine

Parametrised snake body engine for the greedy-snake game. It replaces the fixed 16-segment body logic with a configurable grid size, maximum length and wall mode. It holds the segment coordinates and steps the snake on a move tick, handling direction changes, growth, and wall and body collisions. It sits between key/game control (Step, Dir, Grow, Start) and the LED-array decoder, which reads registered row bitmaps through a scan port.

## Interface
- COORD_W, 4: bits per coordinate axis; the grid is 2^COORD_W × 2^COORD_W (default 16×16).
- MAX_LEN, 32: maximum number of segments.
- INIT_LEN, 3: length after reset or Start; range 2..MAX_LEN, and at most 2^(COORD_W-1).
- WRAP, 0: 0 = a wall hit ends the game; 1 = coordinates wrap modulo 2^COORD_W.
- LEN_W, $clog2(MAX_LEN+1): width of the Length output.

Ports:
- Clk  in  1  system clock; one clock domain only.
- Rst_n  in  1  asynchronous, active-low reset.
- Start  in  1  one-cycle pulse; re-initialises the snake and enters RUN.
- Step  in  1  one-cycle move tick.
- Dir_valid  in  1  qualifies Dir_req.
- Dir_req  in  2  requested direction: 00 up (y-1), 01 down (y+1), 10 left (x-1), 11 right (x+1).
- Grow  in  1  apple-eaten pulse.
- Scan_valid  in  1  row query strobe.
- Scan_row  in  COORD_W  row index being queried.
- State  out  2  00 IDLE, 01 RUN, 10 DEAD.
- Head  out  2*COORD_W  head position as {x,y}.
- Length  out  LEN_W  current number of segments.
- Full  out  1  high when Length==MAX_LEN.
- Hit_wall  out  1  one-cycle pulse on a wall collision.
- Hit_body  out  1  one-cycle pulse on a self collision.
- Body_flat  out  MAX_LEN*2*COORD_W  segments flattened; segment i is {x,y}, segment 0 is the head; entries at i≥Length are 0.
- Row_valid  out  1  high the cycle after Scan_valid.
- Row_bits  out  2^COORD_W  bit c set iff an active segment is at (c, Scan_row).

## Operation
- **Initial snake**, applied at reset and on every accepted Start:
  - cx = cy = 2^(COORD_W-1).
  - Segment i = (cx-i, cy) for i < INIT_LEN.
  - Committed direction = right; pending direction = right; grow_pending = 0.
- **Start**:
  - Accepted in IDLE or DEAD: initialise the snake, then State = RUN.
  - Ignored in RUN.
  - Start wins over a Step in the same cycle.
- **Direction**:
  - In RUN, a Dir_valid request is latched into the pending direction unless it is the opposite of the committed direction (the direction of the last executed move). Opposite requests are dropped.
  - If several requests arrive between steps, the last accepted one wins.
  - A request in the same cycle as Step takes effect on the following Step.
- **Step in RUN**:
  - new head = head + delta(pending direction).
  - Wall check (WRAP=0): new head outside 0..2^COORD_W-1 → State = DEAD, Hit_wall pulse, segments unchanged.
  - Wrap (WRAP=1): new head is taken modulo 2^COORD_W; no wall check.
  - Body check: compare new head against segments 0..Length-2. If a growth applies on this step (see the Growth item), also compare against segment Length-1. A match → State = DEAD, Hit_body pulse, segments unchanged.
  - Otherwise:
    - seg[i] ← seg[i-1] for i ≥ 1; seg[0] ← new head.
    - Committed direction ← pending direction.
    - Growth: if grow_pending (or Grow is high this cycle) and Length < MAX_LEN, then Length+1 and the tail is kept. grow_pending clears on every executed step, including when Full.
- **Grow**:
  - Sets grow_pending (a single bit). Extra Grow pulses before the next step are absorbed.
  - Ignored outside RUN.
- **Step outside RUN**: ignored.
- **Scan port**: active in all states. In DEAD it shows the frozen snake.

## Timing
- All outputs are registered.
- Reset values: State 00; Head {cx,cy}; Length INIT_LEN; Full = (INIT_LEN==MAX_LEN); Hit_wall 0; Hit_body 0; Row_valid 0; Row_bits 0; Body_flat = initial snake.
- State, Head, Length and Body_flat update on the edge that samples Step or Start; they are visible the next cycle.
- Hit_* pulses are exactly one cycle long, coincident with State becoming DEAD.
- Row query latency is 1 cycle. The bitmap reflects segment state at the sampling edge, i.e. before any move on that same edge.
- Reset asserted mid-game returns everything to reset values asynchronously.

## Test plan
- **Reset and scan:** reset, then Scan_row=8 → Head=(8,8), Length=3, State=00, and next cycle Row_valid=1, Row_bits=0x01C0.
- **Wall hit:** Start, then 7 Steps right → Head=(15,8). Step 8 → Hit_wall pulse, State=10, Head stays (15,8). Then Start → State=01, Head=(8,8).
- **Reversal and growth:** in RUN, Dir_req=left → ignored, next Step gives Head=(9,8). Then Grow with Step in the same cycle → Length=4 and the tail is retained.
- **Self collision:** with Length=5 at head (8,8) moving right, Steps up, left, down → third move targets (7,8) → Hit_body, State=10. The same sequence with Length=4 → no hit (tail vacates), Head=(7,8).
- **Wrap mode:** with WRAP=1, from Head=(15,8) a Step right → Head=(0,8), no Hit_wall.
- **Saturation:** with MAX_LEN=4, Grow+Step twice from Length 3 → Length=4, Full=1 after the first. The second growth is dropped and Length stays 4.
